// File: rtl/pid_sched_pkg.sv
// Shared types and helpers for the time-multiplexed PID scheduler.
package pid_sched_pkg;

  // Scheduler state encoding: three cycles per channel (CALC, ISSUE, WAIT)
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CALC  = 2'd1,
    ST_ISSUE = 2'd2,
    ST_WAIT  = 2'd3
  } state_e;

  // Channel index width; a single channel still needs one bit
  function automatic int unsigned chw_of(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pid_sched_sat.sv
// Signed saturator: narrows IN_W to OUT_W, pinning to [MIN_V, MAX_V] instead of wrapping.
module pid_sched_sat #(
  parameter int unsigned            IN_W  = 33,
  parameter int unsigned            OUT_W = 32,
  parameter logic signed [IN_W-1:0] MAX_V = '0,
  parameter logic signed [IN_W-1:0] MIN_V = '0
) (
  input  logic signed [IN_W-1:0]  din,
  output logic signed [OUT_W-1:0] dout_c
);

  // Compare at full input width, then truncate the in-range value
  always_comb begin
    dout_c = OUT_W'(din);
    if (din > MAX_V) begin
      dout_c = OUT_W'(MAX_V);
    end else if (din < MIN_V) begin
      dout_c = OUT_W'(MIN_V);
    end
  end

endmodule

// File: rtl/pid_sched.sv
// Time-multiplexes one external registered PID stage across NCH channels, one round per tick.
module pid_sched
  import pid_sched_pkg::*;
#(
  parameter int unsigned NCH     = 4,
  parameter int unsigned DW      = 32,
  parameter int unsigned KW      = 8,
  parameter int unsigned OW      = 64,
  parameter int unsigned SUM_LIM = 32'd1 << 20
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     tick,
  input  logic [NCH-1:0]           en,
  input  logic [NCH*DW-1:0]        sp,
  input  logic [NCH*DW-1:0]        fb,
  input  logic [NCH*KW-1:0]        kp,
  input  logic [NCH*KW-1:0]        ki,
  input  logic [NCH*KW-1:0]        kd,
  output logic signed [DW-1:0]     pid_error,
  output logic signed [DW-1:0]     pid_error1,
  output logic signed [DW-1:0]     pid_sum_e,
  output logic signed [KW-1:0]     pid_kp,
  output logic signed [KW-1:0]     pid_ki,
  output logic signed [KW-1:0]     pid_kd,
  input  logic signed [OW-1:0]     pid_out,
  output logic                     out_valid,
  output logic [chw_of(NCH)-1:0]   out_ch,
  output logic signed [OW-1:0]     out_data,
  output logic                     busy,
  output logic                     overrun
);

  localparam int unsigned CHW = chw_of(NCH);

  // Error saturates to the DW range; integral clamps symmetrically to +/-SUM_LIM
  localparam logic signed [DW:0]   ERR_MAX = {2'b00, {(DW-1){1'b1}}};
  localparam logic signed [DW:0]   ERR_MIN = {2'b11, {(DW-1){1'b0}}};
  localparam logic signed [DW+1:0] SUM_MAX = (DW+2)'(SUM_LIM);
  localparam logic signed [DW+1:0] SUM_MIN = -SUM_MAX;

  state_e                state_q, state_d;
  logic [CHW-1:0]        ch_q, ch_d;
  logic [NCH-1:0]        en_lat_q, en_lat_d;
  logic signed [DW-1:0]  sum_q [NCH];
  logic signed [DW-1:0]  sum_d [NCH];
  logic signed [DW-1:0]  err1_q [NCH];
  logic signed [DW-1:0]  err1_d [NCH];
  logic signed [DW-1:0]  pid_error_q, pid_error_d;
  logic signed [DW-1:0]  pid_error1_q, pid_error1_d;
  logic signed [DW-1:0]  pid_sum_e_q, pid_sum_e_d;
  logic signed [KW-1:0]  pid_kp_q, pid_kp_d;
  logic signed [KW-1:0]  pid_ki_q, pid_ki_d;
  logic signed [KW-1:0]  pid_kd_q, pid_kd_d;
  logic                  out_valid_q, out_valid_d;
  logic [CHW-1:0]        out_ch_q, out_ch_d;
  logic signed [OW-1:0]  out_data_q, out_data_d;
  logic                  busy_q, busy_d;
  logic                  overrun_q, overrun_d;

  logic signed [DW-1:0]  sp_a [NCH];
  logic signed [DW-1:0]  fb_a [NCH];
  logic signed [KW-1:0]  kp_a [NCH];
  logic signed [KW-1:0]  ki_a [NCH];
  logic signed [KW-1:0]  kd_a [NCH];

  logic signed [DW:0]    diff_c;
  logic signed [DW-1:0]  err_c;
  logic signed [DW+1:0]  sum_raw_c;
  logic signed [DW-1:0]  sum_c;
  logic [CHW-1:0]        first_c;
  logic [CHW-1:0]        nxt_c;
  logic                  nxt_ok_c;

  // Unpack the flat per-channel input buses
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      sp_a[i] = sp[i*DW +: DW];
      fb_a[i] = fb[i*DW +: DW];
      kp_a[i] = kp[i*KW +: KW];
      ki_a[i] = ki[i*KW +: KW];
      kd_a[i] = kd[i*KW +: KW];
    end
  end

  // Error and integral for the channel currently selected by ch_q
  always_comb begin
    diff_c    = {sp_a[ch_q][DW-1], sp_a[ch_q]} - {fb_a[ch_q][DW-1], fb_a[ch_q]};
    sum_raw_c = {{2{sum_q[ch_q][DW-1]}}, sum_q[ch_q]} + {{2{err_c[DW-1]}}, err_c};
  end

  pid_sched_sat #(
    .IN_W (DW + 1),
    .OUT_W(DW),
    .MAX_V(ERR_MAX),
    .MIN_V(ERR_MIN)
  ) u_err_sat (
    .din   (diff_c),
    .dout_c(err_c)
  );

  pid_sched_sat #(
    .IN_W (DW + 2),
    .OUT_W(DW),
    .MAX_V(SUM_MAX),
    .MIN_V(SUM_MIN)
  ) u_sum_sat (
    .din   (sum_raw_c),
    .dout_c(sum_c)
  );

  // Priority encoders: lowest channel in en, and lowest latched channel above ch_q
  always_comb begin
    first_c  = '0;
    nxt_c    = '0;
    nxt_ok_c = 1'b0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (en[i]) begin
        first_c = CHW'(i);
      end
      if (en_lat_q[i] && (CHW'(i) > ch_q)) begin
        nxt_c    = CHW'(i);
        nxt_ok_c = 1'b1;
      end
    end
  end

  // Next-state and register-update logic for the round sequencer
  always_comb begin
    state_d      = state_q;
    ch_d         = ch_q;
    en_lat_d     = en_lat_q;
    sum_d        = sum_q;
    err1_d       = err1_q;
    pid_error_d  = pid_error_q;
    pid_error1_d = pid_error1_q;
    pid_sum_e_d  = pid_sum_e_q;
    pid_kp_d     = pid_kp_q;
    pid_ki_d     = pid_ki_q;
    pid_kd_d     = pid_kd_q;
    out_valid_d  = 1'b0;
    out_ch_d     = out_ch_q;
    out_data_d   = out_data_q;
    busy_d       = busy_q;
    overrun_d    = tick && (state_q != ST_IDLE);

    unique case (state_q)
      ST_IDLE: begin
        if (tick) begin
          en_lat_d = en;
          for (int i = 0; i < NCH; i++) begin
            if (!en[i]) begin
              sum_d[i]  = '0;
              err1_d[i] = '0;
            end
          end
          if (|en) begin
            ch_d    = first_c;
            state_d = ST_CALC;
            busy_d  = 1'b1;
          end
        end
      end
      ST_CALC: begin
        pid_error_d  = err_c;
        pid_error1_d = err1_q[ch_q];
        pid_sum_e_d  = sum_c;
        pid_kp_d     = kp_a[ch_q];
        pid_ki_d     = ki_a[ch_q];
        pid_kd_d     = kd_a[ch_q];
        sum_d[ch_q]  = sum_c;
        state_d      = ST_ISSUE;
      end
      ST_ISSUE: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        out_data_d   = pid_out;
        out_ch_d     = ch_q;
        out_valid_d  = 1'b1;
        err1_d[ch_q] = pid_error_q;
        if (nxt_ok_c) begin
          ch_d    = nxt_c;
          state_d = ST_CALC;
        end else begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and datapath registers; reset aborts any round in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      ch_q         <= '0;
      en_lat_q     <= '0;
      for (int i = 0; i < NCH; i++) begin
        sum_q[i]  <= '0;
        err1_q[i] <= '0;
      end
      pid_error_q  <= '0;
      pid_error1_q <= '0;
      pid_sum_e_q  <= '0;
      pid_kp_q     <= '0;
      pid_ki_q     <= '0;
      pid_kd_q     <= '0;
      out_valid_q  <= 1'b0;
      out_ch_q     <= '0;
      out_data_q   <= '0;
      busy_q       <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      ch_q         <= ch_d;
      en_lat_q     <= en_lat_d;
      sum_q        <= sum_d;
      err1_q       <= err1_d;
      pid_error_q  <= pid_error_d;
      pid_error1_q <= pid_error1_d;
      pid_sum_e_q  <= pid_sum_e_d;
      pid_kp_q     <= pid_kp_d;
      pid_ki_q     <= pid_ki_d;
      pid_kd_q     <= pid_kd_d;
      out_valid_q  <= out_valid_d;
      out_ch_q     <= out_ch_d;
      out_data_q   <= out_data_d;
      busy_q       <= busy_d;
      overrun_q    <= overrun_d;
    end
  end

  assign pid_error  = pid_error_q;
  assign pid_error1 = pid_error1_q;
  assign pid_sum_e  = pid_sum_e_q;
  assign pid_kp     = pid_kp_q;
  assign pid_ki     = pid_ki_q;
  assign pid_kd     = pid_kd_q;
  assign out_valid  = out_valid_q;
  assign out_ch     = out_ch_q;
  assign out_data   = out_data_q;
  assign busy       = busy_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_pid_sched.sv
// Directed bench for pid_sched: two instances (default clamp and SUM_LIM=100) share stimulus.
module tb_pid_sched;

  logic         clk = 1'b0;
  logic         rst;
  logic         tick;
  logic [3:0]   en;
  logic [127:0] sp, fb;
  logic [31:0]  kp, ki, kd;

  logic signed [31:0] pid_error, pid_error1, pid_sum_e;
  logic signed [7:0]  pid_kp, pid_ki, pid_kd;
  logic signed [63:0] pid_out, out_data;
  logic               out_valid, busy, overrun;
  logic [1:0]         out_ch;

  logic signed [31:0] l_pid_error, l_pid_error1, l_pid_sum_e;
  logic signed [7:0]  l_pid_kp, l_pid_ki, l_pid_kd;
  logic signed [63:0] l_pid_out, l_out_data;
  logic               l_out_valid, l_busy, l_overrun;
  logic [1:0]         l_out_ch;

  always #5 clk = ~clk;

  pid_sched dut (
    .clk(clk), .rst(rst), .tick(tick), .en(en), .sp(sp), .fb(fb),
    .kp(kp), .ki(ki), .kd(kd),
    .pid_error(pid_error), .pid_error1(pid_error1), .pid_sum_e(pid_sum_e),
    .pid_kp(pid_kp), .pid_ki(pid_ki), .pid_kd(pid_kd), .pid_out(pid_out),
    .out_valid(out_valid), .out_ch(out_ch), .out_data(out_data),
    .busy(busy), .overrun(overrun)
  );

  pid_sched #(.SUM_LIM(100)) dut_l (
    .clk(clk), .rst(rst), .tick(tick), .en(en), .sp(sp), .fb(fb),
    .kp(kp), .ki(ki), .kd(kd),
    .pid_error(l_pid_error), .pid_error1(l_pid_error1), .pid_sum_e(l_pid_sum_e),
    .pid_kp(l_pid_kp), .pid_ki(l_pid_ki), .pid_kd(l_pid_kd), .pid_out(l_pid_out),
    .out_valid(l_out_valid), .out_ch(l_out_ch), .out_data(l_out_data),
    .busy(l_busy), .overrun(l_overrun)
  );

  // Reference PID stage: kp*e + ki*sum + kd*(e - e_prev), one register of latency
  function automatic longint pid_calc(input logic signed [7:0] kp_v, input logic signed [7:0] ki_v,
                                      input logic signed [7:0] kd_v, input logic signed [31:0] e,
                                      input logic signed [31:0] e1, input logic signed [31:0] s);
    return longint'(kp_v) * longint'(e) + longint'(ki_v) * longint'(s)
         + longint'(kd_v) * (longint'(e) - longint'(e1));
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      pid_out   <= '0;
      l_pid_out <= '0;
    end else begin
      pid_out   <= pid_calc(pid_kp, pid_ki, pid_kd, pid_error, pid_error1, pid_sum_e);
      l_pid_out <= pid_calc(l_pid_kp, l_pid_ki, l_pid_kd, l_pid_error, l_pid_error1, l_pid_sum_e);
    end
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [3:0]  en;
    logic [31:0] sp_v, fb_v;
    logic [7:0]  kp_v, ki_v, kd_v;
    int          xt;
    int          n_out;
    int          ch_f, cyc_f;
    longint      data_f;
    int          ch_l, cyc_l;
    longint      data_l;
    int          busy_n, ov_n;
    logic [31:0] err, sum, sum_l;
  } vec_t;

  vec_t vt [12];

  int          obs_n, l_obs_n, busy_n, ov_n;
  int          obs_ch [8];
  int          obs_cyc [8];
  longint      obs_data [8];
  logic [31:0] cap_err, cap_sum, cap_suml;
  logic        busy_end;

  // Channel i gets setpoint sp_v + 10*i so channel selection errors show up
  task automatic set_inputs(input logic [31:0] sp_v, input logic [31:0] fb_v,
                            input logic [7:0] kp_v, input logic [7:0] ki_v, input logic [7:0] kd_v);
    for (int i = 0; i < 4; i++) begin
      sp[i*32 +: 32] = sp_v + 32'(10 * i);
      fb[i*32 +: 32] = fb_v;
      kp[i*8 +: 8]   = kp_v;
      ki[i*8 +: 8]   = ki_v;
      kd[i*8 +: 8]   = kd_v;
    end
  endtask

  // Pulse tick now (at a negedge), optionally again at cycle xt; observe 15 cycles
  task automatic run_round(input logic [3:0] en_v, input int xt);
    obs_n = 0; l_obs_n = 0; busy_n = 0; ov_n = 0;
    for (int j = 0; j < 8; j++) begin
      obs_ch[j] = -1; obs_cyc[j] = -1; obs_data[j] = -1;
    end
    en   = en_v;
    tick = 1'b1;
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      tick = (k == xt);
      if (out_valid) begin
        if (obs_n < 8) begin
          obs_ch[obs_n]   = int'(out_ch);
          obs_cyc[obs_n]  = k;
          obs_data[obs_n] = out_data;
        end
        obs_n++;
      end
      if (l_out_valid) l_obs_n++;
      if (busy) busy_n++;
      if (overrun) ov_n++;
      if (k == 2) begin
        cap_err  = pid_error;
        cap_sum  = pid_sum_e;
        cap_suml = l_pid_sum_e;
      end
    end
    busy_end = busy | l_busy;
  endtask

  initial begin
    int last;
    int nv;
    rst = 1'b1; tick = 1'b0; en = '0; sp = '0; fb = '0; kp = '0; ki = '0; kd = '0;

    //        en      sp             fb             kp    ki    kd   xt n  chf cyf data_f                ch_l cyl data_l               busy ov err            sum            sum_l
    vt[0]  = '{4'b0001, 32'd100,      32'd40,       8'd2, 8'd1, 8'd1, 0, 1, 0, 4, 64'sd240,             0, 4,  64'sd240,             3,  0, 32'd60,        32'd60,        32'd60};
    vt[1]  = '{4'b0001, 32'd100,      32'd40,       8'd2, 8'd1, 8'd1, 0, 1, 0, 4, 64'sd240,             0, 4,  64'sd240,             3,  0, 32'd60,        32'd120,       32'd100};
    vt[2]  = '{4'b1010, 32'd100,      32'd40,       8'd2, 8'd1, 8'd1, 0, 2, 1, 4, 64'sd280,             3, 7,  64'sd360,             6,  0, 32'd70,        32'd70,        32'd70};
    vt[3]  = '{4'b1010, 32'd100,      32'd40,       8'd2, 8'd1, 8'd1, 2, 2, 1, 4, 64'sd280,             3, 7,  64'sd360,             6,  1, 32'd70,        32'd140,       32'd100};
    vt[4]  = '{4'b1111, 32'd100,      32'd40,       8'd1, 8'd1, 8'd0, 0, 4, 0, 4, 64'sd120,             3, 13, 64'sd360,             12, 0, 32'd60,        32'd60,        32'd60};
    vt[5]  = '{4'b0000, 32'd100,      32'd40,       8'd1, 8'd1, 8'd0, 0, 0, 0, 0, 64'sd0,               0, 0,  64'sd0,               0,  0, 32'd90,        32'd270,       32'd100};
    vt[6]  = '{4'b0001, 32'd80,       32'd0,        8'd0, 8'd1, 8'd0, 0, 1, 0, 4, 64'sd80,              0, 4,  64'sd80,              3,  0, 32'd80,        32'd80,        32'd80};
    vt[7]  = '{4'b0001, 32'd80,       32'd0,        8'd0, 8'd1, 8'd0, 0, 1, 0, 4, 64'sd160,             0, 4,  64'sd160,             3,  0, 32'd80,        32'd160,       32'd100};
    vt[8]  = '{4'b0001, 32'd80,       32'd0,        8'd0, 8'd1, 8'd0, 0, 1, 0, 4, 64'sd240,             0, 4,  64'sd240,             3,  0, 32'd80,        32'd240,       32'd100};
    vt[9]  = '{4'b0001, 32'h7FFFFFFF, 32'h80000000, 8'd1, 8'd0, 8'd0, 0, 1, 0, 4, 64'sd2147483647,      0, 4,  64'sd2147483647,      3,  0, 32'h7FFFFFFF,  32'd1048576,   32'd100};
    vt[10] = '{4'b0001, 32'h80000000, 32'h7FFFFFFF, 8'd1, 8'd0, 8'd0, 0, 1, 0, 4, -64'sd2147483648,     0, 4,  -64'sd2147483648,     3,  0, 32'h80000000,  32'hFFF00000,  32'hFFFFFF9C};
    vt[11] = '{4'b0001, 32'd0,        32'd10,       8'd0, 8'd0, 8'd3, 0, 1, 0, 4, 64'sd6442450914,      0, 4,  64'sd6442450914,      3,  0, 32'hFFFFFFF6,  32'hFFF00000,  32'hFFFFFF9C};

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_out_valid", longint'(out_valid), 0);
    chk("rst_busy",      longint'(busy), 0);
    chk("rst_overrun",   longint'(overrun), 0);
    chk("rst_out_data",  out_data, 0);
    chk("rst_out_ch",    longint'(out_ch), 0);
    chk("rst_pid_error", longint'(pid_error), 0);
    chk("rst_pid_sum_e", longint'(pid_sum_e), 0);
    rst = 1'b0;
    @(negedge clk);

    // Table of rounds; sums and previous errors carry from one row to the next
    for (int v = 0; v < 12; v++) begin
      set_inputs(vt[v].sp_v, vt[v].fb_v, vt[v].kp_v, vt[v].ki_v, vt[v].kd_v);
      run_round(vt[v].en, vt[v].xt);
      chk($sformatf("v%0d_nout", v),     longint'(obs_n), longint'(vt[v].n_out));
      chk($sformatf("v%0d_l_nout", v),   longint'(l_obs_n), longint'(vt[v].n_out));
      chk($sformatf("v%0d_busy", v),     longint'(busy_n), longint'(vt[v].busy_n));
      chk($sformatf("v%0d_overrun", v),  longint'(ov_n), longint'(vt[v].ov_n));
      chk($sformatf("v%0d_busy_end", v), longint'(busy_end), 0);
      chk($sformatf("v%0d_err", v),      longint'(cap_err), longint'(vt[v].err));
      chk($sformatf("v%0d_sum", v),      longint'(cap_sum), longint'(vt[v].sum));
      chk($sformatf("v%0d_sum_l", v),    longint'(cap_suml), longint'(vt[v].sum_l));
      if (vt[v].n_out > 0) begin
        nv   = (obs_n > 8) ? 8 : obs_n;
        last = (nv > 0) ? nv - 1 : 0;
        chk($sformatf("v%0d_ch_first", v),   longint'(obs_ch[0]), longint'(vt[v].ch_f));
        chk($sformatf("v%0d_cyc_first", v),  longint'(obs_cyc[0]), longint'(vt[v].cyc_f));
        chk($sformatf("v%0d_data_first", v), obs_data[0], vt[v].data_f);
        chk($sformatf("v%0d_ch_last", v),    longint'(obs_ch[last]), longint'(vt[v].ch_l));
        chk($sformatf("v%0d_cyc_last", v),   longint'(obs_cyc[last]), longint'(vt[v].cyc_l));
        chk($sformatf("v%0d_data_last", v),  obs_data[last], vt[v].data_l);
      end
    end

    // Reset in the WAIT cycle of ch0 aborts the round
    set_inputs(32'd100, 32'd40, 8'd2, 8'd1, 8'd1);
    en   = 4'b0001;
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("abort_busy_before", longint'(busy), 1);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_out_valid", longint'(out_valid), 0);
    chk("abort_busy",      longint'(busy), 0);
    chk("abort_out_data",  out_data, 0);
    chk("abort_pid_error", longint'(pid_error), 0);
    chk("abort_pid_err1",  longint'(pid_error1), 0);
    chk("abort_pid_sum_e", longint'(pid_sum_e), 0);
    rst = 1'b0;
    nv  = 0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid) nv++;
    end
    chk("abort_no_valid", longint'(nv), 0);

    // Fresh round after reset starts from a zero integral and zero previous error
    run_round(4'b0001, 0);
    chk("restart_nout", longint'(obs_n), 1);
    chk("restart_cyc",  longint'(obs_cyc[0]), 4);
    chk("restart_data", obs_data[0], 240);
    chk("restart_sum",  longint'(cap_sum), 60);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
